// File: rtl/cam_cfg_sequencer.sv
// cam_cfg_sequencer: walks a configuration table and issues serial-engine
// transfers, interleaving single host transfers at entry boundaries.
// Optional feature macro: CAM_CFG_TIMEOUT_EN (WAIT_HI watchdog, 16 cycles).
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | no run active; serves a pending host request or starts a run
// FETCH    | tbl_addr presented; pending host request takes priority here
// DECODE   | tbl_data sampled and dispatched (XFER/DELAY/NOP/END)
// ISSUE    | eng_start high for this single cycle
// WAIT_HI  | waiting for the engine to raise eng_busy
// WAIT_LO  | waiting for the engine to drop eng_busy (transfer end)
// DELAY    | down-counting a table delay entry
module cam_cfg_sequencer #(
  parameter int TBL_AW = 8,
  parameter int DLY_W  = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              init_go,
  output logic              init_done,
  output logic              init_err,
  output logic [TBL_AW-1:0] tbl_addr,
  input  logic [31:0]       tbl_data,
  input  logic              host_start,
  input  logic [31:0]       host_dataout,
  input  logic [1:0]        host_wr,
  output logic              host_busy,
  output logic [31:0]       host_datain,
  output logic              eng_start,
  input  logic              eng_busy,
  output logic [31:0]       eng_dataout,
  output logic [1:0]        eng_wr,
  input  logic [31:0]       eng_datain
);

  typedef enum logic [2:0] {
    IDLE, FETCH, DECODE, ISSUE, WAIT_HI, WAIT_LO, DELAY
  } state_e;

  state_e              state_q, state_d;
  logic [TBL_AW-1:0]   tbl_addr_q, tbl_addr_d;
  logic                init_done_q, init_done_d;
  logic                init_err_q, init_err_d;
  logic                run_q, run_d;
  logic                pend_q, pend_d;
  logic                host_act_q, host_act_d;
  logic                host_busy_q, host_busy_d;
  logic [31:0]         host_dat_q, host_dat_d;
  logic [1:0]          host_wr_q, host_wr_d;
  logic [31:0]         host_datain_q, host_datain_d;
  logic                eng_start_q, eng_start_d;
  logic [31:0]         eng_dataout_q, eng_dataout_d;
  logic [1:0]          eng_wr_q, eng_wr_d;
  logic [DLY_W-1:0]    dly_cnt_q, dly_cnt_d;
`ifdef CAM_CFG_TIMEOUT_EN
  logic [3:0]          to_cnt_q, to_cnt_d;
`endif

  logic advance, xfer_end, timed_out;
  logic unused_bits;

  // entry bits 27:24 carry no meaning for any opcode
  assign unused_bits = ^tbl_data[27:24];

  // next-state and output computation for the sequencer
  always_comb begin
    state_d       = state_q;
    tbl_addr_d    = tbl_addr_q;
    init_done_d   = init_done_q;
    init_err_d    = init_err_q;
    run_d         = run_q;
    pend_d        = pend_q;
    host_act_d    = host_act_q;
    host_dat_d    = host_dat_q;
    host_wr_d     = host_wr_q;
    host_datain_d = host_datain_q;
    eng_start_d   = 1'b0;
    eng_dataout_d = eng_dataout_q;
    eng_wr_d      = eng_wr_q;
    dly_cnt_d     = dly_cnt_q;
`ifdef CAM_CFG_TIMEOUT_EN
    to_cnt_d      = to_cnt_q;
`endif
    advance       = 1'b0;
    xfer_end      = 1'b0;
    timed_out     = 1'b0;

    // host_busy_q already covers pending and active, so a held request blocks new ones
    if (host_start && !host_busy_q) begin
      pend_d     = 1'b1;
      host_dat_d = host_dataout;
      host_wr_d  = host_wr;
    end

    case (state_q)
      IDLE: begin
        // a run started here still reaches FETCH, where a same-cycle host request wins
        if (init_go) begin
          init_done_d = 1'b0;
          init_err_d  = 1'b0;
          tbl_addr_d  = '0;
          run_d       = 1'b1;
          state_d     = FETCH;
        end else if (pend_q) begin
          eng_dataout_d = host_dat_q;
          eng_wr_d      = host_wr_q;
          host_act_d    = 1'b1;
          pend_d        = 1'b0;
          eng_start_d   = 1'b1;
          state_d       = ISSUE;
        end
      end
      FETCH: begin
        if (pend_q) begin
          eng_dataout_d = host_dat_q;
          eng_wr_d      = host_wr_q;
          host_act_d    = 1'b1;
          pend_d        = 1'b0;
          eng_start_d   = 1'b1;
          state_d       = ISSUE;
        end else begin
          state_d = DECODE;
        end
      end
      DECODE: begin
        case (tbl_data[31:30])
          2'b00: begin
            eng_wr_d      = tbl_data[29:28];
            eng_dataout_d = {8'h00, tbl_data[23:0]};
            host_act_d    = 1'b0;
            eng_start_d   = 1'b1;
            state_d       = ISSUE;
          end
          2'b01: begin
            if (tbl_data[DLY_W-1:0] == '0) begin
              advance = 1'b1;
            end else begin
              dly_cnt_d = tbl_data[DLY_W-1:0];
              state_d   = DELAY;
            end
          end
          2'b11: begin
            init_done_d = 1'b1;
            run_d       = 1'b0;
            state_d     = IDLE;
          end
          default: advance = 1'b1;
        endcase
      end
      ISSUE: begin
`ifdef CAM_CFG_TIMEOUT_EN
        to_cnt_d = 4'd15;
`endif
        state_d = WAIT_HI;
      end
      WAIT_HI: begin
        if (eng_busy) begin
          state_d = WAIT_LO;
        end
`ifdef CAM_CFG_TIMEOUT_EN
        else if (to_cnt_q == 4'd0) begin
          xfer_end  = 1'b1;
          timed_out = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q - 4'd1;
        end
`endif
      end
      WAIT_LO: begin
        if (!eng_busy) xfer_end = 1'b1;
      end
      DELAY: begin
        if (dly_cnt_q == DLY_W'(1)) advance = 1'b1;
        else dly_cnt_d = dly_cnt_q - DLY_W'(1);
      end
      default: state_d = IDLE;
    endcase

    if (xfer_end) begin
      if (host_act_q) begin
        host_datain_d = eng_datain;
        host_act_d    = 1'b0;
        state_d       = run_q ? FETCH : IDLE;
      end else begin
        advance = 1'b1;
        if (timed_out) init_err_d = 1'b1;
      end
    end

    // the last table slot terminates the run instead of wrapping to 0
    if (advance) begin
      if (tbl_addr_q == {TBL_AW{1'b1}}) begin
        init_done_d = 1'b1;
        run_d       = 1'b0;
        state_d     = IDLE;
      end else begin
        tbl_addr_d = tbl_addr_q + 1'b1;
        state_d    = FETCH;
      end
    end

    host_busy_d = pend_d | host_act_d;
  end

  // state and registered outputs, cleared asynchronously
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= IDLE;
      tbl_addr_q    <= '0;
      init_done_q   <= 1'b0;
      init_err_q    <= 1'b0;
      run_q         <= 1'b0;
      pend_q        <= 1'b0;
      host_act_q    <= 1'b0;
      host_busy_q   <= 1'b0;
      host_dat_q    <= '0;
      host_wr_q     <= '0;
      host_datain_q <= '0;
      eng_start_q   <= 1'b0;
      eng_dataout_q <= '0;
      eng_wr_q      <= '0;
      dly_cnt_q     <= '0;
`ifdef CAM_CFG_TIMEOUT_EN
      to_cnt_q      <= '0;
`endif
    end else begin
      state_q       <= state_d;
      tbl_addr_q    <= tbl_addr_d;
      init_done_q   <= init_done_d;
      init_err_q    <= init_err_d;
      run_q         <= run_d;
      pend_q        <= pend_d;
      host_act_q    <= host_act_d;
      host_busy_q   <= host_busy_d;
      host_dat_q    <= host_dat_d;
      host_wr_q     <= host_wr_d;
      host_datain_q <= host_datain_d;
      eng_start_q   <= eng_start_d;
      eng_dataout_q <= eng_dataout_d;
      eng_wr_q      <= eng_wr_d;
      dly_cnt_q     <= dly_cnt_d;
`ifdef CAM_CFG_TIMEOUT_EN
      to_cnt_q      <= to_cnt_d;
`endif
    end
  end

  assign tbl_addr    = tbl_addr_q;
  assign init_done   = init_done_q;
  assign init_err    = init_err_q;
  assign host_busy   = host_busy_q;
  assign host_datain = host_datain_q;
  assign eng_start   = eng_start_q;
  assign eng_dataout = eng_dataout_q;
  assign eng_wr      = eng_wr_q;

endmodule

// File: tb/tb_cam_cfg_sequencer.sv
// Directed bench for cam_cfg_sequencer with a 4-entry table (TBL_AW=2),
// a synchronous-read table model and a simple serial-engine model.
module tb_cam_cfg_sequencer;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        init_go = 1'b0;
  logic        init_done, init_err;
  logic [1:0]  tbl_addr;
  logic [31:0] tbl_data = '0;
  logic        host_start = 1'b0;
  logic [31:0] host_dataout = '0;
  logic [1:0]  host_wr = '0;
  logic        host_busy;
  logic [31:0] host_datain;
  logic        eng_start;
  logic        eng_busy;
  logic [31:0] eng_dataout;
  logic [1:0]  eng_wr;
  logic [31:0] eng_datain;

  int n_chk = 0;
  int n_fail = 0;

  logic [31:0] mem [0:3];
  logic [31:0] log_data [0:63];
  logic [1:0]  log_wr [0:63];
  int          n_start = 0;
  int          dbl_start = 0;
  int          stab_err = 0;
  int          busy_cnt = 0;
  logic        prev_start = 1'b0;
  logic        eng_stuck = 1'b0;

  cam_cfg_sequencer #(.TBL_AW(2), .DLY_W(16)) dut (
    .clk(clk), .rstn(rstn), .init_go(init_go), .init_done(init_done),
    .init_err(init_err), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
    .host_start(host_start), .host_dataout(host_dataout), .host_wr(host_wr),
    .host_busy(host_busy), .host_datain(host_datain), .eng_start(eng_start),
    .eng_busy(eng_busy), .eng_dataout(eng_dataout), .eng_wr(eng_wr),
    .eng_datain(eng_datain)
  );

  always #5 clk = ~clk;

  // table memory: data follows the address by one clock
  always @(posedge clk) tbl_data <= mem[tbl_addr];

  // engine: busy from the clock after eng_start for 10 cycles; readback = data ^ 5A5A0000
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      eng_busy   <= 1'b0;
      eng_datain <= '0;
      busy_cnt   <= 0;
      prev_start <= 1'b0;
    end else begin
      prev_start <= eng_start;
      if (eng_start && prev_start) dbl_start <= dbl_start + 1;
      if (eng_start) begin
        if (n_start < 64) begin
          log_data[n_start] <= eng_dataout;
          log_wr[n_start]   <= eng_wr;
        end
        n_start <= n_start + 1;
      end
      if (eng_busy && n_start > 0 && n_start <= 64 &&
          (eng_dataout != log_data[n_start-1] || eng_wr != log_wr[n_start-1]))
        stab_err <= stab_err + 1;
      if (eng_start && !eng_stuck) begin
        eng_busy   <= 1'b1;
        busy_cnt   <= 9;
        eng_datain <= eng_dataout ^ 32'h5A5A_0000;
      end else if (busy_cnt != 0) begin
        busy_cnt <= busy_cnt - 1;
      end else begin
        eng_busy <= 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic run_table(output int cyc);
    @(negedge clk);
    init_go = 1'b1;
    @(negedge clk);
    init_go = 1'b0;
    cyc = 1;
    chk("go_clears_done", {31'd0, init_done}, 32'd0);
    while (!init_done && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    chk("run_done", {31'd0, init_done}, 32'd1);
  endtask

  task automatic wait_starts(input int target);
    int b;
    b = 0;
    while (n_start < target && b < 500) begin
      @(negedge clk);
      b++;
    end
    chk("start_seen", n_start, target);
  endtask

  int cyc, base;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_done", {31'd0, init_done}, 32'd0);
    chk("rst_addr", {30'd0, tbl_addr}, 32'd0);
    chk("rst_busy", {31'd0, host_busy}, 32'd0);
    chk("rst_estart", {31'd0, eng_start}, 32'd0);
    rstn = 1'b1;
    @(negedge clk);

    // single XFER then END
    mem[0] = 32'h1000_AB12; mem[1] = 32'hC000_0000; mem[2] = '0; mem[3] = '0;
    base = n_start;
    run_table(cyc);
    chk("x_nstart", n_start - base, 1);
    chk("x_wr", {30'd0, log_wr[base]}, 32'd1);
    chk("x_data", log_data[base], 32'h0000_AB12);
    chk("x_err", {31'd0, init_err}, 32'd0);
    chk("x_hdin", host_datain, 32'd0);
    chk("x_addr", {30'd0, tbl_addr}, 32'd1);

    // DELAY 5 and DELAY 3: done visible 5+N cycles after init_go
    mem[0] = 32'h4000_0005; mem[1] = 32'hC000_0000;
    base = n_start;
    run_table(cyc);
    chk("d5_cycles", cyc, 10);
    chk("d5_nstart", n_start - base, 0);
    mem[0] = 32'h4000_0003;
    run_table(cyc);
    chk("d3_cycles", cyc, 8);
    mem[0] = 32'h4000_0000;
    run_table(cyc);
    chk("d0_cycles", cyc, 5);

    // host request during first table transfer, then a second ignored request
    mem[0] = 32'h2000_0011; mem[1] = 32'h3000_0022; mem[2] = 32'hC000_0000;
    base = n_start;
    fork
      run_table(cyc);
      begin
        wait_starts(base + 1);
        host_start = 1'b1; host_dataout = 32'h0000_1234; host_wr = 2'd2;
        @(negedge clk);
        host_start = 1'b0;
        chk("h_busy_set", {31'd0, host_busy}, 32'd1);
        host_start = 1'b1; host_dataout = 32'h0000_9999; host_wr = 2'd1;
        @(negedge clk);
        host_start = 1'b0;
      end
    join
    chk("h_nstart", n_start - base, 3);
    chk("h_first", log_data[base], 32'h0000_0011);
    chk("h_host", log_data[base+1], 32'h0000_1234);
    chk("h_host_wr", {30'd0, log_wr[base+1]}, 32'd2);
    chk("h_resume", log_data[base+2], 32'h0000_0022);
    chk("h_resume_wr", {30'd0, log_wr[base+2]}, 32'd3);
    chk("h_datain", host_datain, 32'h5A5A_1234);
    chk("h_busy_clr", {31'd0, host_busy}, 32'd0);

    // host request from IDLE: no table access, done flag left alone
    base = n_start;
    @(negedge clk);
    host_start = 1'b1; host_dataout = 32'hA5A5_0F0F; host_wr = 2'd3;
    chk("i_busy_pre", {31'd0, host_busy}, 32'd0);
    @(negedge clk);
    host_start = 1'b0;
    chk("i_busy_set", {31'd0, host_busy}, 32'd1);
    cyc = 0;
    while (host_busy && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    chk("i_nstart", n_start - base, 1);
    chk("i_data", log_data[base], 32'hA5A5_0F0F);
    chk("i_datain", host_datain, 32'hFFFF_0F0F);
    chk("i_done_kept", {31'd0, init_done}, 32'd1);
    chk("i_addr_kept", {30'd0, tbl_addr}, 32'd2);

    // simultaneous host_start and init_go: host first
    mem[0] = 32'h1000_0033; mem[1] = 32'hC000_0000;
    base = n_start;
    @(negedge clk);
    host_start = 1'b1; host_dataout = 32'h0000_BEEF; host_wr = 2'd1;
    init_go = 1'b1;
    @(negedge clk);
    host_start = 1'b0; init_go = 1'b0;
    cyc = 0;
    while (!init_done && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    chk("s_done", {31'd0, init_done}, 32'd1);
    chk("s_nstart", n_start - base, 2);
    chk("s_host_first", log_data[base], 32'h0000_BEEF);
    chk("s_table", log_data[base+1], 32'h0000_0033);
    chk("s_datain", host_datain, 32'h5A5A_BEEF);

    // full table, no END: stop after last slot without wrapping
    mem[0] = 32'h1000_0001; mem[1] = 32'h1000_0002;
    mem[2] = 32'h1000_0003; mem[3] = 32'h1000_0004;
    base = n_start;
    run_table(cyc);
    chk("w_nstart", n_start - base, 4);
    chk("w_last", log_data[base+3], 32'h0000_0004);
    chk("w_addr", {30'd0, tbl_addr}, 32'd3);
    chk("w_datain", host_datain, 32'h5A5A_BEEF);

    // reset in WAIT_LO, then restart from entry 0
    mem[0] = 32'h1000_0077; mem[1] = 32'hC000_0000;
    base = n_start;
    @(negedge clk);
    init_go = 1'b1;
    @(negedge clk);
    init_go = 1'b0;
    wait_starts(base + 1);
    repeat (3) @(negedge clk);
    chk("r_in_xfer", {31'd0, eng_busy}, 32'd1);
    rstn = 1'b0;
    #1;
    chk("r_done", {31'd0, init_done}, 32'd0);
    chk("r_addr", {30'd0, tbl_addr}, 32'd0);
    chk("r_hdin", host_datain, 32'd0);
    chk("r_edata", eng_dataout, 32'd0);
    chk("r_ewr", {30'd0, eng_wr}, 32'd0);
    chk("r_hbusy", {31'd0, host_busy}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    base = n_start;
    run_table(cyc);
    chk("r_restart", log_data[base], 32'h0000_0077);
    chk("r_nstart", n_start - base, 1);

`ifdef CAM_CFG_TIMEOUT_EN
    // stuck engine: timeout flags init_err and the run still finishes
    eng_stuck = 1'b1;
    base = n_start;
    run_table(cyc);
    chk("t_err", {31'd0, init_err}, 32'd1);
    chk("t_nstart", n_start - base, 1);
    eng_stuck = 1'b0;
`endif

    chk("one_cycle_start", dbl_start, 0);
    chk("xfer_stable", stab_err, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
